fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, instruction FIFO entries (power of two, 2..16).
REQ-002 Parameter RESET_PC, default 64'h0, byte address of first fetch after reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 imem_req_valid  output  1  fetch request to instruction memory.
REQ-006 imem_req_ready  input  1  memory accepts request this cycle.
REQ-007 imem_req_addr  output  64  word-aligned byte address of request.
REQ-008 imem_rsp_valid  input  1  instruction word returned (in request order, latency >=1).
REQ-009 imem_rsp_data  input  32  returned instruction word.
REQ-010 redirect_valid  input  1  taken branch / PC override from execute (one-cycle pulse).
REQ-011 redirect_pc  input  64  new fetch byte address; bits [1:0] ignored, treated as 0.
REQ-012 inst_valid  output  1  FIFO head valid toward decode.
REQ-013 inst_ready  input  1  decode consumes head this cycle.
REQ-014 inst_data  output  32  head instruction word.
REQ-015 inst_pc  output  64  byte address of head instruction.
REQ-016 occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.

Function
REQ-017 Request handshake: request transfers when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (64-bit wrap, no saturation).
REQ-018 imem_req_valid = !redirect_valid && (occupancy + outstanding < DEPTH); imem_req_addr = fetch_pc, held stable while valid and not accepted.
REQ-019 outstanding counts accepted requests not yet answered; it increments on request transfer and decrements on imem_rsp_valid; both in one cycle leave it unchanged.
REQ-020 imem_rsp_valid while outstanding == 0 is ignored (no state change).
REQ-021 A response with drop_cnt > 0 is discarded and drop_cnt decrements; otherwise {rsp_pc, imem_rsp_data} is pushed and rsp_pc advances by 4.
REQ-022 Output handshake: head pops when inst_valid && inst_ready; inst_data/inst_pc held stable while inst_valid && !inst_ready.
REQ-023 Push and pop in one cycle are both performed; occupancy unchanged; no push when full is possible by construction (REQ-018).
REQ-024 Redirect cycle: inst_valid forced 0, no request issued, no pop; at the edge FIFO is flushed (occupancy 0), fetch_pc and rsp_pc load redirect_pc, drop_cnt loads outstanding minus 1 if imem_rsp_valid that cycle, else outstanding.
REQ-025 A response arriving in the redirect cycle is discarded regardless of drop_cnt.
REQ-026 Back-to-back redirects: last one wins; drop_cnt always recomputed from outstanding per REQ-024.
REQ-027 Peak throughput: one instruction per cycle with single-cycle memory and inst_ready held high.
REQ-028 First request after reset deasserts is presented in the first cycle with reset low.

Reset
REQ-029 While reset is high: imem_req_valid=0, inst_valid=0, occupancy=0, inst_data=0, inst_pc=0, imem_req_addr=RESET_PC.
REQ-030 At reset edge: fetch_pc=rsp_pc=RESET_PC, outstanding=0, drop_cnt=0, FIFO pointers 0; reset mid-operation discards all buffered and in-flight state, memory is reset by the same signal.

Structure
REQ-031 Shared package fetch_pkg holds ADDR_W=64, INSTR_W=32, PC_STEP=4, DEPTH default, and packed struct fetch_entry_t {pc, instr}.
REQ-032 Storage is sub-module fetch_fifo (synchronous FIFO of fetch_entry_t with flush, push, pop, count); counters and PC registers live in fetch_queue.

Verification
REQ-033 Reset release, memory latency 1, inst_ready=1 -> inst_pc 0x0,0x4,0x8,... one per cycle, inst_data matches memory image.
REQ-034 inst_ready=0 for 10 cycles -> occupancy saturates at 4, imem_req_valid low, head stays inst_pc=0x0; release -> 0x0..0xC drained in order, no loss.
REQ-035 Memory latency 3, two requests outstanding, redirect_pc=0x100 -> both stale responses dropped, next inst_pc=0x100 with data from 0x100.
REQ-036 Redirect coincident with imem_rsp_valid and inst_ready -> that response dropped, no pop counted, next inst_pc=redirect_pc.
REQ-037 redirect_pc=0xFFFF_FFFF_FFFF_FFFC -> inst_pc sequence 0x...FFFC then 0x0.
REQ-038 Reset asserted with occupancy 3 and 2 outstanding -> next cycle occupancy=0, inst_valid=0, first request addr=RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Imported by the interface, the FIFO and the fetch_queue top.
package fetch_pkg;

    localparam int ADDR_W = 64;
    localparam int INSTR_W = 32;
    localparam int DEFAULT_DEPTH = 4;
    localparam logic [ADDR_W-1:0] PC_STEP = 64'd4;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] align_pc(
        input logic [ADDR_W-1:0] pc
    );
        return pc & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Handshake bundle between fetch_queue, instruction memory,
// execute (redirect) and decode.
interface fetch_queue_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [ADDR_W-1:0]  imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               inst_valid;
    logic               inst_ready;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready,
        input  imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready,
        output imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of fetch entries with flush and entry count.
// DEPTH is a power of two so the pointers wrap naturally.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       push_entry,
    output fetch_entry_t       head,
    output logic [CNT_W-1:0]   count
);

    fetch_entry_t mem_q [DEPTH];
    fetch_entry_t mem_d [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_entry;
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            count_d = count_q + CNT_W'(push)
                    - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
        mem_q <= mem_d;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential fetches, buffers
// in-order responses for decode, and flushes on redirect.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    fetch_queue_if.master    bus,
    output logic [CNT_W-1:0] occupancy
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   inflight;
    logic             redirect;
    logic             req_valid;
    logic             req_fire;
    logic             rsp_take;
    logic             push;
    logic             pop;
    logic             inst_valid;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;

    assign redirect = bus.redirect_valid;

    // Buffered plus in-flight never exceeds DEPTH, so a push
    // always finds a free slot.
    always_comb begin
        inflight = {1'b0, fifo_count}
                 + {1'b0, outstanding_q};
        req_valid = !reset && !redirect
                 && (inflight < (CNT_W+1)'(DEPTH));
        req_fire = req_valid && bus.imem_req_ready;
        rsp_take = bus.imem_rsp_valid
                && (outstanding_q != '0);
        push = rsp_take && !redirect
            && (drop_cnt_q == '0);
        inst_valid = !reset && !redirect
                  && (fifo_count != '0);
        pop = inst_valid && bus.inst_ready;
        push_entry.pc    = rsp_pc_q;
        push_entry.instr = bus.imem_rsp_data;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        rsp_pc_d      = rsp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q
                      + CNT_W'(req_fire)
                      - CNT_W'(rsp_take);
        if (redirect) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
            rsp_pc_d   = align_pc(bus.redirect_pc);
            drop_cnt_d = outstanding_q
                       - CNT_W'(rsp_take);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + PC_STEP;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + PC_STEP;
            end
            if (rsp_take && drop_cnt_q != '0) begin
                drop_cnt_d = drop_cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            rsp_pc_q      <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .flush      (redirect),
        .push       (push),
        .pop        (pop),
        .push_entry (push_entry),
        .head       (head),
        .count      (fifo_count)
    );

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = reset ? RESET_PC
                                      : fetch_pc_q;
    assign bus.inst_valid = inst_valid;
    assign bus.inst_data  = reset ? '0 : head.instr;
    assign bus.inst_pc    = reset ? '0 : head.pc;
    assign occupancy      = reset ? '0 : fifo_count;

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed
// corner sequences and randomized traffic against a queue model.
module tb_fetch_queue;
    import fetch_pkg::*;

    localparam int DEPTH = 4;
    localparam logic [63:0] RPC = 64'h0;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] occupancy;

    fetch_queue_if bus();

    fetch_queue #(
        .DEPTH    (DEPTH),
        .RESET_PC (RPC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .occupancy (occupancy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [63:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [63:0] addr;
        bit          stale;
    } infl_t;

    mreq_t        memq[$];
    infl_t        m_infl[$];
    fetch_entry_t m_fifo[$];
    logic [63:0]  m_fpc;

    int lat = 1;
    int stall_pct = 0;
    int rdy_pct = 100;
    bit spur_en = 0;

    bit          s_fire, s_rsp_mem, s_reset, s_redir;
    bit          m_fire, m_pop, m_rsp;
    logic [63:0] s_addr, s_rpc;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return (a[33:2] * 32'h9E37_79B9) ^ 32'h1357_9BDF ^ a[63:32];
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Drive memory side for this cycle, then check against the model.
    task automatic pre();
        bit exp_rv, exp_iv;
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        if (!reset) begin
            if (memq.size() > 0) begin
                if (memq[0].due <= cyc && $urandom_range(99) >= stall_pct) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(memq[0].addr);
                end
            end else if (spur_en && $urandom_range(3) == 0) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = $urandom;
            end
        end
        #1;
        if (reset) begin
            exp_rv = 0;
            exp_iv = 0;
            chk("rst_req_valid", bus.imem_req_valid, 0);
            chk("rst_req_addr", bus.imem_req_addr, RPC);
            chk("rst_inst_valid", bus.inst_valid, 0);
            chk("rst_inst_data", bus.inst_data, 0);
            chk("rst_inst_pc", bus.inst_pc, 0);
            chk("rst_occ", occupancy, 0);
        end else begin
            exp_rv = !bus.redirect_valid && (m_fifo.size() + m_infl.size() < DEPTH);
            exp_iv = !bus.redirect_valid && (m_fifo.size() > 0);
            chk("req_valid", bus.imem_req_valid, exp_rv);
            if (exp_rv) chk("req_addr", bus.imem_req_addr, m_fpc);
            chk("inst_valid", bus.inst_valid, exp_iv);
            if (exp_iv) begin
                chk("inst_pc", bus.inst_pc, m_fifo[0].pc);
                chk("inst_data", bus.inst_data, m_fifo[0].instr);
            end
            chk("occupancy", occupancy, m_fifo.size());
        end
        s_fire    = bus.imem_req_valid && bus.imem_req_ready;
        s_addr    = bus.imem_req_addr;
        s_rsp_mem = bus.imem_rsp_valid && (memq.size() > 0);
        s_reset   = reset;
        s_redir   = bus.redirect_valid;
        s_rpc     = bus.redirect_pc;
        m_fire    = exp_rv && bus.imem_req_ready;
        m_pop     = exp_iv && bus.inst_ready;
        m_rsp     = bus.imem_rsp_valid && (m_infl.size() > 0);
    endtask

    task automatic post();
        infl_t e;
        @(posedge clk);
        if (s_reset) begin
            memq.delete();
        end else begin
            if (s_rsp_mem) void'(memq.pop_front());
            if (s_fire) memq.push_back('{s_addr, cyc + lat});
        end
        if (s_reset) begin
            m_fifo.delete();
            m_infl.delete();
            m_fpc = RPC;
        end else if (s_redir) begin
            m_fifo.delete();
            if (m_rsp) void'(m_infl.pop_front());
            foreach (m_infl[i]) m_infl[i].stale = 1;
            m_fpc = {s_rpc[63:2], 2'b00};
        end else begin
            if (m_pop) void'(m_fifo.pop_front());
            if (m_rsp) begin
                e = m_infl.pop_front();
                if (!e.stale) m_fifo.push_back('{e.addr, mem_word(e.addr)});
            end
            if (m_fire) begin
                m_infl.push_back('{m_fpc, 1'b0});
                m_fpc = m_fpc + 64'd4;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic step();
        pre();
        post();
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        for (int i = 0; i < n; i++) step();
        reset = 1'b0;
    endtask

    task automatic expect_next(input string name, input logic [63:0] pc,
                               input int maxc);
        bit seen = 0;
        for (int i = 0; i < maxc && !seen; i++) begin
            pre();
            if (bus.inst_valid) begin
                seen = 1;
                chk({name, "_pc"}, bus.inst_pc, pc);
                chk({name, "_data"}, bus.inst_data, mem_word(pc));
            end
            post();
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL %s timeout got=none exp_pc=%h", name, pc);
        end
    endtask

    typedef struct {
        bit          ready;
        bit          exp_iv;
        logic [63:0] exp_pc;
        int          exp_occ;
        bit          exp_rv;
        logic [63:0] exp_addr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        reset = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        m_fpc = RPC;

        // Latency-1 memory: fill while decode stalls, then drain.
        tbl[0]  = '{0, 0, 64'h0,  0, 1, 64'h0};
        tbl[1]  = '{0, 0, 64'h0,  0, 1, 64'h4};
        tbl[2]  = '{0, 1, 64'h0,  1, 1, 64'h8};
        tbl[3]  = '{0, 1, 64'h0,  2, 1, 64'hC};
        tbl[4]  = '{0, 1, 64'h0,  3, 0, 64'h10};
        tbl[5]  = '{0, 1, 64'h0,  4, 0, 64'h10};
        tbl[6]  = '{0, 1, 64'h0,  4, 0, 64'h10};
        tbl[7]  = '{0, 1, 64'h0,  4, 0, 64'h10};
        tbl[8]  = '{0, 1, 64'h0,  4, 0, 64'h10};
        tbl[9]  = '{0, 1, 64'h0,  4, 0, 64'h10};
        tbl[10] = '{1, 1, 64'h0,  4, 0, 64'h10};
        tbl[11] = '{1, 1, 64'h4,  3, 1, 64'h10};
        tbl[12] = '{1, 1, 64'h8,  2, 1, 64'h14};
        tbl[13] = '{1, 1, 64'hC,  2, 1, 64'h18};
        tbl[14] = '{1, 1, 64'h10, 2, 1, 64'h1C};

        lat = 1; stall_pct = 0; rdy_pct = 100; spur_en = 0;
        do_reset(2);
        for (int i = 0; i < 15; i++) begin
            bus.inst_ready = tbl[i].ready;
            pre();
            chk("tbl_inst_valid", bus.inst_valid, tbl[i].exp_iv);
            if (tbl[i].exp_iv) begin
                chk("tbl_inst_pc", bus.inst_pc, tbl[i].exp_pc);
                chk("tbl_inst_data", bus.inst_data, mem_word(tbl[i].exp_pc));
            end
            chk("tbl_occ", occupancy, tbl[i].exp_occ);
            chk("tbl_req_valid", bus.imem_req_valid, tbl[i].exp_rv);
            chk("tbl_req_addr", bus.imem_req_addr, tbl[i].exp_addr);
            post();
        end

        // Two stale requests in flight at redirect.
        lat = 3;
        bus.inst_ready = 1'b1;
        do_reset(1);
        step();
        step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h100;
        step();
        bus.redirect_valid = 1'b0;
        expect_next("redir_stale", 64'h100, 30);

        // Redirect coincides with a response and a ready decode.
        lat = 1;
        do_reset(1);
        for (int i = 0; i < 4; i++) step();
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'h203;
        pre();
        chk("coinc_rsp_present", bus.imem_rsp_valid, 1);
        chk("coinc_inst_valid", bus.inst_valid, 0);
        chk("coinc_req_valid", bus.imem_req_valid, 0);
        post();
        bus.redirect_valid = 1'b0;
        expect_next("coinc_next", 64'h200, 20);
        expect_next("coinc_next2", 64'h204, 20);

        // Address wrap at the top of the 64-bit space.
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 64'hFFFF_FFFF_FFFF_FFFC;
        step();
        bus.redirect_valid = 1'b0;
        expect_next("wrap_top", 64'hFFFF_FFFF_FFFF_FFFC, 20);
        expect_next("wrap_zero", 64'h0, 20);

        // Reset while buffered and in-flight entries exist.
        lat = 2;
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 6; i++) step();
        reset = 1'b1;
        pre();
        chk("midrst_occ", occupancy, 0);
        post();
        reset = 1'b0;
        pre();
        chk("midrst_occ_after", occupancy, 0);
        chk("midrst_inst_valid", bus.inst_valid, 0);
        chk("midrst_req_valid", bus.imem_req_valid, 1);
        chk("midrst_req_addr", bus.imem_req_addr, RPC);
        post();
        bus.inst_ready = 1'b1;
        expect_next("midrst_first", RPC, 20);

        // Randomized traffic against the model.
        spur_en = 1;
        for (int i = 0; i < 4000; i++) begin
            if (i % 200 == 0) begin
                lat       = $urandom_range(1, 4);
                stall_pct = $urandom_range(0, 40);
                rdy_pct   = $urandom_range(30, 100);
            end
            reset = ($urandom_range(399) == 0);
            bus.inst_ready = ($urandom_range(3) != 0);
            bus.redirect_valid = ($urandom_range(19) == 0);
            if ($urandom_range(3) == 0)
                bus.redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(15));
            else
                bus.redirect_pc = {32'($urandom), 32'($urandom)};
            step();
        end
        reset = 1'b0;
        bus.redirect_valid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
